// File: rtl/snac_db15_reader_if.sv
// Signal bundle between the SNAC DB15 serial front end and its surroundings:
// the adapter pins plus the deserialised joystick words.
`timescale 1ns/1ps

interface snac_db15_reader_if;
  // Adapter side: JOY_DATA is asynchronous; JOY_CLK and JOY_LOAD are strobes
  // with no handshake. Core side: frame_valid is a one-cycle strobe with no
  // ready; joystick1/joystick2 are updated in the same cycle as frame_valid
  // and hold until the next frame, so a consumer may sample them at any time.
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_valid;

  modport master (
    input  JOY_DATA,
    output JOY_CLK,
    output JOY_LOAD,
    output joystick1,
    output joystick2,
    output frame_valid
  );

  modport slave (
    output JOY_DATA,
    input  JOY_CLK,
    input  JOY_LOAD,
    input  joystick1,
    input  joystick2,
    input  frame_valid
  );
endinterface

// File: rtl/snac_db15_reader.sv
// Continuous scanner for the SNAC DB15 adapter: strobes two cascaded shift
// registers and publishes 24 button bits as two joystick words per frame.
`timescale 1ns/1ps

module snac_db15_reader #(
  parameter int CLK_DIV   = 48,
  parameter int GAP_TICKS = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  snac_db15_reader_if.master   bus,
  output logic [2:0]           state_dbg
);

  localparam int              CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_TICKS - 1);
  localparam logic [4:0]      BIT_LAST  = 5'd23;

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_SETTLE   = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_COMMIT   = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   ph_cnt;
  logic [4:0]    bit_idx;
  logic [23:0]   sh;
  logic [1:0]    data_sync;
  logic          d_s;
  logic          sample_en;

  assign tick      = (tick_cnt == TICK_LAST);
  assign d_s       = data_sync[1];
  assign state_dbg = state;

  // Next-state and sample strobe; every transition except COMMIT waits for a tick.
  always_comb begin
    state_next = state;
    sample_en  = 1'b0;
    case (state)
      S_LOAD: begin
        if (tick && ph_cnt == 16'd1) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (tick) begin
          sample_en  = 1'b1;
          state_next = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick) state_next = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (tick) begin
          sample_en  = 1'b1;
          state_next = (bit_idx == BIT_LAST) ? S_COMMIT : S_SHIFT_HI;
        end
      end
      S_COMMIT: begin
        state_next = S_GAP;
      end
      S_GAP: begin
        if (tick && ph_cnt == GAP_LAST) state_next = S_LOAD;
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOAD;
      tick_cnt  <= '0;
      ph_cnt    <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      data_sync <= 2'b11;
    end else begin
      state     <= state_next;
      data_sync <= {data_sync[0], bus.JOY_DATA};

      // COMMIT restarts the tick grid so GAP begins with a full tick.
      if (state == S_COMMIT || tick) tick_cnt <= '0;
      else                           tick_cnt <= tick_cnt + 1'b1;

      if (state_next != state) ph_cnt <= '0;
      else if (tick)           ph_cnt <= ph_cnt + 16'd1;

      if (sample_en) sh[bit_idx] <= ~d_s;

      if (state == S_COMMIT)
        bit_idx <= '0;
      else if (sample_en && bit_idx != BIT_LAST)
        bit_idx <= bit_idx + 5'd1;
    end
  end

  // Strobes are registered from the next state so they align with the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.JOY_LOAD    <= 1'b1;
      bus.JOY_CLK     <= 1'b0;
      bus.joystick1   <= '0;
      bus.joystick2   <= '0;
      bus.frame_valid <= 1'b0;
    end else begin
      bus.JOY_LOAD    <= (state_next != S_LOAD);
      bus.JOY_CLK     <= (state_next == S_SHIFT_HI);
      bus.frame_valid <= (state == S_COMMIT);
      if (state == S_COMMIT) begin
        bus.joystick1 <= {4'b0000, sh[11:0]};
        bus.joystick2 <= {4'b0000, sh[23:12]};
      end
    end
  end

endmodule

// File: tb/tb_snac_db15_reader.sv
// Bench for snac_db15_reader: a default-parameter instance with an idle pad and
// a fast instance (CLK_DIV=4, GAP_TICKS=1) driven by a behavioural adapter.
`timescale 1ns/1ps

module tb_snac_db15_reader;

  localparam int FRAME_A = (2 + 1 + 46 + 200) * 48 + 1;
  localparam int FRAME_B = (2 + 1 + 46 + 1) * 4 + 1;
  localparam int FIRST_B = (2 + 1 + 46) * 4 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  snac_db15_reader_if bus_a();
  snac_db15_reader_if bus_b();
  logic [2:0] dbg_a;
  logic [2:0] dbg_b;

  snac_db15_reader dut_a (
    .clk       (clk),
    .reset     (rst_a),
    .bus       (bus_a),
    .state_dbg (dbg_a)
  );

  snac_db15_reader #(.CLK_DIV(4), .GAP_TICKS(1)) dut_b (
    .clk       (clk),
    .reset     (rst_b),
    .bus       (bus_b),
    .state_dbg (dbg_b)
  );

  // ---------------- adapter model ----------------
  // pat_b holds pressed buttons (1 = pressed); the pin shows bit[pos] inverted,
  // pos = number of JOY_CLK rises since the last parallel load.
  logic [23:0] pat_b = 24'h0;
  int          pos_b = 0;
  logic        data_b;

  always @(posedge bus_b.JOY_CLK or negedge bus_b.JOY_LOAD) begin
    if (!bus_b.JOY_LOAD) pos_b <= 0;
    else                 pos_b <= pos_b + 1;
  end

  always_comb begin
    data_b = 1'b1;
    if (pos_b >= 0 && pos_b < 24) data_b = ~pat_b[pos_b[4:0]];
  end

  assign bus_a.JOY_DATA = 1'b1;
  assign bus_b.JOY_DATA = data_b;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  bit          upper_nz = 1'b0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (bus_a.joystick1[15:12] != 4'h0 || bus_a.joystick2[15:12] != 4'h0 ||
        bus_b.joystick1[15:12] != 4'h0 || bus_b.joystick2[15:12] != 4'h0)
      upper_nz = 1'b1;
  end

  function automatic logic [31:0] ref_words(input logic [23:0] p);
    ref_words = {4'h0, p[23:12], 4'h0, p[11:0]};
  endfunction

  function automatic logic [31:0] words_b();
    words_b = {bus_b.joystick2, bus_b.joystick1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_fv(input bit on_a, input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      ok = on_a ? bus_a.frame_valid : bus_b.frame_valid;
    end
  endtask

  task automatic wait_pos(input int target, input int limit, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      ok = (pos_b == target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int n;
    bit ok;
    rst_a = 1'b1;
    rst_b = 1'b1;
    pat_b = 24'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_b.JOY_LOAD !== 1'b1) begin errors++; $display("FAIL reset_load: got %b expected 1", bus_b.JOY_LOAD); end
    checks++;
    if (bus_b.JOY_CLK !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", bus_b.JOY_CLK); end
    checks++;
    if (words_b() !== 32'h0) begin errors++; $display("FAIL reset_words: got %h expected 0", words_b()); end
    checks++;
    if (bus_b.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", bus_b.frame_valid); end
    checks++;
    if (bus_a.JOY_LOAD !== 1'b1 || bus_a.JOY_CLK !== 1'b0) begin
      errors++; $display("FAIL reset_a_strobes: got load=%b clk=%b expected load=1 clk=0", bus_a.JOY_LOAD, bus_a.JOY_CLK);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_fv(1'b0, FIRST_B + 50, n, ok);
    checks++;
    if (!ok || n != FIRST_B) begin errors++; $display("FAIL first_frame_latency: got %0d (seen=%0b) expected %0d", n, ok, FIRST_B); end
    checks++;
    if (words_b() !== 32'h0) begin errors++; $display("FAIL first_frame_words: got %h expected 0", words_b()); end
  endtask

  task automatic test_fixed_pattern;
    int n;
    bit ok;
    pat_b = (24'h1 << 0) | (24'h1 << 5) | (24'h1 << 12) | (24'h1 << 23);
    wait_fv(1'b0, FRAME_B + 20, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fixed_fv: got timeout expected pulse"); end
    checks++;
    if (bus_b.joystick1 !== 16'h0021) begin errors++; $display("FAIL fixed_j1: got %h expected 0021", bus_b.joystick1); end
    checks++;
    if (bus_b.joystick2 !== 16'h0801) begin errors++; $display("FAIL fixed_j2: got %h expected 0801", bus_b.joystick2); end
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      pat_b = 24'($urandom);
      exp_q.push_back(ref_words(pat_b));
      wait_fv(1'b0, FRAME_B + 20, n, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || n != FRAME_B) begin errors++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", i, n, FRAME_B); end
      checks++;
      if (words_b() !== exp) begin errors++; $display("FAIL b2b_words[%0d]: got %h expected %h", i, words_b(), exp); end
    end
  endtask

  task automatic test_strobes;
    int n, loads, load_w, load_run, rises, bad_hi, bad_lo, overlap, hi_run, lo_run;
    bit done, after_fall, prev_clk, prev_load, cur_clk, cur_load;
    for (int f = 0; f < 3; f++) begin
      n = 0; loads = 0; load_w = -1; load_run = 0; rises = 0; bad_hi = 0; bad_lo = 0;
      overlap = 0; hi_run = 0; lo_run = 0; done = 1'b0; after_fall = 1'b0;
      prev_clk = bus_b.JOY_CLK; prev_load = bus_b.JOY_LOAD;
      while (!done && n < FRAME_B + 50) begin
        @(negedge clk);
        n++;
        cur_clk  = bus_b.JOY_CLK;
        cur_load = bus_b.JOY_LOAD;
        if (cur_clk && !cur_load) overlap++;
        if (!cur_load) load_run++;
        if (cur_load && !prev_load) begin loads++; load_w = load_run; load_run = 0; end
        if (cur_clk && !prev_clk) begin
          rises++;
          if (after_fall && lo_run != 4) bad_lo++;
          hi_run = 0;
        end
        if (!cur_clk && prev_clk) begin
          if (hi_run != 4) bad_hi++;
          after_fall = 1'b1;
          lo_run = 0;
        end
        if (cur_clk) hi_run++; else lo_run++;
        if (bus_b.frame_valid) done = 1'b1;
        prev_clk  = cur_clk;
        prev_load = cur_load;
      end
      checks++;
      if (!done || n != FRAME_B) begin errors++; $display("FAIL strobe_frame_len[%0d]: got %0d expected %0d", f, n, FRAME_B); end
      checks++;
      if (loads != 1 || load_w != 8) begin errors++; $display("FAIL strobe_load[%0d]: got %0d pulses width %0d expected 1 pulse width 8", f, loads, load_w); end
      checks++;
      if (rises != 23) begin errors++; $display("FAIL strobe_rises[%0d]: got %0d expected 23", f, rises); end
      checks++;
      if (bad_hi != 0 || bad_lo != 0) begin errors++; $display("FAIL strobe_phase[%0d]: got bad_hi=%0d bad_lo=%0d expected 0", f, bad_hi, bad_lo); end
      checks++;
      if (overlap != 0) begin errors++; $display("FAIL strobe_overlap[%0d]: got %0d expected 0", f, overlap); end
    end
  endtask

  task automatic test_stability;
    int n, hold_bad;
    bit ok, hit, got;
    logic [23:0] old_p, new_p, mix_p;
    old_p = 24'($urandom);
    new_p = old_p ^ (24'($urandom) | 24'h800801);
    mix_p = (old_p & 24'h0003FF) | (new_p & 24'hFFFC00);
    pat_b = old_p;
    wait_fv(1'b0, FRAME_B + 20, n, ok);
    checks++;
    if (!ok || words_b() !== ref_words(old_p)) begin
      errors++; $display("FAIL stab_prev: got %h expected %h", words_b(), ref_words(old_p));
    end
    n = 0; hold_bad = 0; hit = 1'b0; got = 1'b0;
    while (!hit && n < FRAME_B + 20) begin
      @(negedge clk);
      n++;
      if (words_b() !== ref_words(old_p)) hold_bad++;
      hit = (pos_b == 10);
    end
    pat_b = new_p;
    checks++;
    if (!hit) begin errors++; $display("FAIL stab_reach_bit10: got timeout expected bit 10"); end
    while (!got && n < 2 * FRAME_B) begin
      @(negedge clk);
      n++;
      if (bus_b.frame_valid) got = 1'b1;
      else if (words_b() !== ref_words(old_p)) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL stab_hold: got %0d changed cycles expected 0", hold_bad); end
    checks++;
    if (!got || words_b() !== ref_words(mix_p)) begin
      errors++; $display("FAIL stab_mixed: got %h expected %h", words_b(), ref_words(mix_p));
    end
    wait_fv(1'b0, FRAME_B + 20, n, ok);
    checks++;
    if (!ok || words_b() !== ref_words(new_p)) begin
      errors++; $display("FAIL stab_new: got %h expected %h", words_b(), ref_words(new_p));
    end
  endtask

  task automatic test_reset_mid_frame;
    int n, early_bad;
    bit ok, got;
    pat_b = 24'hFFFFFF;
    wait_pos(11, 2 * FRAME_B, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_reach_bit11: got timeout expected bit 11"); end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    n = 0; early_bad = 0; got = 1'b0;
    while (!got && n < FIRST_B + 50) begin
      @(negedge clk);
      n++;
      if (bus_b.frame_valid) got = 1'b1;
      else if (words_b() !== 32'h0) early_bad++;
    end
    checks++;
    if (early_bad != 0) begin errors++; $display("FAIL midrst_outputs_zero: got %0d nonzero cycles expected 0", early_bad); end
    checks++;
    if (!got || n != FIRST_B) begin errors++; $display("FAIL midrst_latency: got %0d (seen=%0b) expected %0d", n, got, FIRST_B); end
    checks++;
    if (bus_b.joystick1 !== 16'h0FFF || bus_b.joystick2 !== 16'h0FFF) begin
      errors++; $display("FAIL midrst_words: got %h %h expected 0fff 0fff", bus_b.joystick1, bus_b.joystick2);
    end
  endtask

  task automatic test_all_pressed;
    int n;
    bit ok;
    pat_b = 24'hFFFFFF;
    wait_fv(1'b0, FRAME_B + 20, n, ok);
    checks++;
    if (!ok || words_b() !== ref_words(24'hFFFFFF)) begin
      errors++; $display("FAIL all_pressed: got %h expected %h", words_b(), ref_words(24'hFFFFFF));
    end
    checks++;
    if (upper_nz) begin errors++; $display("FAIL upper_bits: got nonzero expected 0"); end
  endtask

  task automatic test_idle_default;
    int n;
    bit ok;
    wait_fv(1'b1, FRAME_A + 100, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_fv: got timeout expected pulse"); end
    checks++;
    if (bus_a.joystick1 !== 16'h0 || bus_a.joystick2 !== 16'h0) begin
      errors++; $display("FAIL idle_words: got %h %h expected 0000 0000", bus_a.joystick1, bus_a.joystick2);
    end
    wait_fv(1'b1, FRAME_A + 100, n, ok);
    checks++;
    if (!ok || n != FRAME_A) begin errors++; $display("FAIL idle_interval: got %0d expected %0d", n, FRAME_A); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fixed_pattern();
    test_back_to_back();
    test_strobes();
    test_stability();
    test_reset_mid_frame();
    test_all_pressed();
    test_idle_default();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snac_db15_reader.md
# snac_db15_reader

Serial front end for the SNAC DB15 adapter on the MiSTer user port. Drives the load and shift strobes of the adapter's two cascaded parallel-in shift registers and deserialises 24 active-low button bits. Presents them as two active-high 16-bit joystick words, which the core's input muxing selects in place of USB joysticks. Runs continuously from its own clock and updates both words atomically once per scan frame.

## Interface
- `CLK_DIV`, 48: clock cycles per tick. One tick is one half-period of `JOY_CLK`. Must be ≥ 4. At 48 MHz the default gives a 1 µs tick.
- `GAP_TICKS`, 200: idle ticks between the end of one frame and the next load. Range 1..65535.
- `clk`  in  1  block clock (48 MHz in the core).
- `reset`  in  1  synchronous, active-high.
- `JOY_DATA`  in  1  serial data from the adapter; asynchronous; active-low buttons.
- `JOY_CLK`  out  1  shift clock to the adapter; registered.
- `JOY_LOAD`  out  1  parallel load to the adapter, active-low; registered.
- `joystick1`  out  16  player 1 buttons, active-high. Bits [11:0] = serial bits 0..11. Bits [15:12] = 0.
- `joystick2`  out  16  player 2 buttons, active-high. Bits [11:0] = serial bits 12..23. Bits [15:12] = 0.
- `frame_valid`  out  1  one-cycle pulse in the cycle the joystick words update.

## Operation
- `JOY_DATA` passes through a 2-flop synchroniser before use. All sampling described below uses the synchronised value `d_s`.
- A tick counter counts 0..CLK_DIV-1. `tick` is asserted when the count equals CLK_DIV-1. All state transitions and strobe changes happen only on `tick`.
- State machine:
  - LOAD: `JOY_LOAD`=0, `JOY_CLK`=0, held for 2 ticks → SETTLE.
  - SETTLE: `JOY_LOAD`=1, `JOY_CLK`=0, held for 1 tick. On its final tick, sample `~d_s` into shift bit 0 → SHIFT_HI with bit index 1.
  - SHIFT_HI: `JOY_CLK`=1, held for 1 tick → SHIFT_LO. The rising edge advances the adapter.
  - SHIFT_LO: `JOY_CLK`=0, held for 1 tick. On its final tick, sample `~d_s` into bit[index]. If index = 23 → COMMIT; otherwise increment index → SHIFT_HI.
  - COMMIT: lasts exactly one clock and is not tick-gated.
    - `joystick1` ← {4'b0, sh[11:0]}.
    - `joystick2` ← {4'b0, sh[23:12]}.
    - Pulse `frame_valid`.
    - Clear the tick counter → GAP.
  - GAP: `JOY_LOAD`=1, `JOY_CLK`=0 for GAP_TICKS ticks → LOAD.
- The shift buffer `sh[23:0]` is internal. The output words change only in COMMIT and never show a partial frame.
- Reset behaviour:
  - Clears the tick counter, bit index and `sh`.
  - Drives `joystick1`=`joystick2`=0, `frame_valid`=0, `JOY_CLK`=0, `JOY_LOAD`=1, and sets state = LOAD.
  - Reset asserted mid-frame discards the partial frame; the outputs read 0 until the next full COMMIT.
- `JOY_LOAD` and `JOY_CLK` are never both active. `JOY_CLK` is 0 whenever `JOY_LOAD` is 0.

## Timing
- First LOAD tick ends CLK_DIV cycles after `reset` deasserts.
- `JOY_LOAD` low pulse width: exactly 2·CLK_DIV cycles.
- `JOY_CLK` pulses: exactly 23 rising edges per frame. Each high and each low phase lasts exactly CLK_DIV cycles.
- Sampling instant:
  - Each bit is sampled CLK_DIV cycles after the preceding `JOY_CLK` rise, or after the `JOY_LOAD` rise for bit 0.
  - Data must be stable at the pin by CLK_DIV-3 cycles after that edge, to allow for the 2-cycle synchroniser latency.
- Frame length: (2 + 1 + 46 + GAP_TICKS)·CLK_DIV + 1 cycles. With the defaults this is 249·48 + 1 = 11953 cycles.
- `frame_valid` rises in the same cycle the new words first appear on the outputs.

## Test plan
- `JOY_DATA` held 1, defaults:
  - After the first frame, `frame_valid` pulses once and both words = 16'h0000.
  - The next pulse follows exactly 11953 cycles later.
- Adapter model (24-bit active-low shifter) loaded with button bits 0, 5, 12 and 23 pressed:
  - `joystick1` = 16'h0021.
  - `joystick2` = 16'h0801.
- Strobe checker over 3 frames, CLK_DIV=4, GAP_TICKS=1:
  - Each frame shows one `JOY_LOAD` low pulse of 8 cycles and 23 `JOY_CLK` rises, each phase 4 cycles.
  - `JOY_CLK` is never high while `JOY_LOAD` is low.
- Output stability: the model changes its pattern mid-shift of frame N.
  - Outputs hold frame N-1 values until the frame N COMMIT, then show the mixed capture.
  - Frame N+1 shows the new pattern in full.
- Reset pulsed for 1 cycle after bit 10 of a frame with all buttons pressed:
  - Outputs stay 0 with no `frame_valid` until a full new frame completes.
  - Both words then read 16'h0FFF.
- Simultaneous all-pressed pattern:
  - Both words = 16'h0FFF.
  - Bits [15:12] stay 0 throughout.
